// File: rtl/imem_stream_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
// Holds the FSM state encoding and the frame constants used by the loader and its word assembler.
package imem_stream_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_WRITE,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam int         FRAME_HDR_BYTES = 2;
   localparam logic [7:0] CHK_INIT        = 8'h00;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and imem write port of the loader, bundled as one interface.
// The slave modport is the loader; the master modport is the stream source plus memory side.
interface imem_stream_loader_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  mem_wEn;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_dataIn;

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, mem_wEn, mem_addr, mem_dataIn
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, mem_wEn, mem_addr, mem_dataIn
   );
endinterface

// File: rtl/imem_stream_loader_word_assembler.sv
// Packs accepted bytes little-endian into a word and XOR-accumulates the checksum.
// word_full and word_nxt are combinational on the byte that completes a word; state updates on the edge.
module word_assembler
   import imem_stream_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [7:0]            byte_in,
   output logic                  word_full,
   output logic [DATA_WIDTH-1:0] word_nxt,
   output logic [7:0]            checksum
);
   localparam int BPW = DATA_WIDTH / 8;
   localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [IW-1:0]         idx;
   logic [DATA_WIDTH-1:0] word_q;

   always_comb begin
      word_nxt               = word_q;
      word_nxt[idx*8 +: 8]   = byte_in;
      word_full              = accept && (idx == IW'(BPW - 1));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx      <= '0;
         word_q   <= '0;
         checksum <= CHK_INIT;
      end else if (clear) begin
         idx      <= '0;
         word_q   <= '0;
         checksum <= CHK_INIT;
      end else if (accept) begin
         word_q   <= word_nxt;
         checksum <= checksum ^ byte_in;
         idx      <= word_full ? '0 : idx + 1'b1;
      end
   end
endmodule

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed, XOR-checked byte stream into imem and holds the CPU in reset until verified.
// One write cycle per word; byte_ready is low outside LEN/DATA/CHECK and during the write cycle.
module imem_stream_loader
   import imem_stream_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   imem_stream_loader_if.slave  bus,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);
   state_t                state;
   logic [15:0]           len;
   logic [ADDR_WIDTH:0]   word_idx;
   logic [ADDR_WIDTH:0]   words_next;
   logic [15:0]           len_next;
   logic                  len_bad;
   logic                  last_word;
   logic                  accept;
   logic                  asm_accept;
   logic                  asm_clear;
   logic                  word_full;
   logic [DATA_WIDTH-1:0] word_nxt;
   logic [7:0]            checksum;

   assign accept     = bus.byte_valid && bus.byte_ready;
   assign asm_accept = accept && (state == ST_DATA);
   assign asm_clear  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   assign len_next   = {bus.byte_in, len[7:0]};
   assign len_bad    = (len_next == 16'd0) || (32'(len_next) > (32'd1 << ADDR_WIDTH));
   assign words_next = word_idx + 1'b1;
   // Word index is one bit wider than the address so a full-capacity image terminates cleanly.
   assign last_word  = (32'(words_next) == 32'(len));

   word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
      .clock     (clock),
      .reset     (reset),
      .clear     (asm_clear),
      .accept    (asm_accept),
      .byte_in   (bus.byte_in),
      .word_full (word_full),
      .word_nxt  (word_nxt),
      .checksum  (checksum)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         len            <= '0;
         word_idx       <= '0;
         bus.byte_ready <= 1'b0;
         bus.mem_wEn    <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_dataIn <= '0;
         cpu_hold       <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state          <= ST_LEN_LO;
                  len            <= '0;
                  word_idx       <= '0;
                  bus.mem_addr   <= '0;
                  bus.byte_ready <= 1'b1;
                  cpu_hold       <= 1'b1;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  error          <= 1'b0;
               end
            end
            ST_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= bus.byte_in;
                  state    <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (accept) begin
                  len <= len_next;
                  if (len_bad) begin
                     state          <= ST_ERR;
                     bus.byte_ready <= 1'b0;
                     busy           <= 1'b0;
                     error          <= 1'b1;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (word_full) begin
                  state          <= ST_WRITE;
                  bus.byte_ready <= 1'b0;
                  bus.mem_wEn    <= 1'b1;
                  bus.mem_addr   <= word_idx[ADDR_WIDTH-1:0];
                  bus.mem_dataIn <= word_nxt;
               end
            end
            ST_WRITE: begin
               bus.mem_wEn    <= 1'b0;
               bus.byte_ready <= 1'b1;
               word_idx       <= words_next;
               state          <= last_word ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
               if (accept) begin
                  bus.byte_ready <= 1'b0;
                  busy           <= 1'b0;
                  if (bus.byte_in == checksum) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ST_ERR;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: frames, bad checksum/length, back-to-back stream,
// mid-load reset and a full-capacity image, checked with immediate assertions.
module tb_imem_stream_loader;
   logic clock = 1'b0;
   logic reset;
   logic start;
   logic cpu_hold, busy, done, error;

   int tests = 0;
   int fails = 0;

   logic [11:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [7:0]  data_q[$];
   logic [31:0] exp_w[$];
   int          ready_in_write = 0;

   imem_stream_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bif ();

   imem_stream_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .bus      (bif),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (bif.mem_wEn) begin
         wr_addr_q.push_back(bif.mem_addr);
         wr_data_q.push_back(bif.mem_dataIn);
         if (bif.byte_ready) ready_in_write++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      bif.byte_in    = b;
      bif.byte_valid = 1'b1;
      while (!bif.byte_ready && t < 64) begin
         @(negedge clock);
         t++;
      end
      if (!bif.byte_ready) begin
         tests++;
         fails++;
         $error("FAIL byte_ready_wait observed=timeout expected=ready byte=%h", b);
      end
      @(negedge clock);
   endtask

   task automatic send_body(input logic [15:0] n);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      foreach (data_q[i]) send_byte(data_q[i]);
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      ready_in_write = 0;
   endtask

   task automatic load_basic(input logic [7:0] chk);
      data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
      clear_log();
      pulse_start();
      send_body(16'd2);
      send_byte(chk);
      bif.byte_valid = 1'b0;
   endtask

   initial begin
      logic [7:0]  chk;
      logic [31:0] w;
      int          zero_cnt;

      reset          = 1'b1;
      start          = 1'b0;
      bif.byte_in    = 8'h00;
      bif.byte_valid = 1'b0;
      #12;
      check("rst_byte_ready", bif.byte_ready, 1'b0);
      check("rst_mem_wEn",    bif.mem_wEn,    1'b0);
      check("rst_mem_addr",   bif.mem_addr,   12'h000);
      check("rst_mem_dataIn", bif.mem_dataIn, 32'h0);
      check("rst_cpu_hold",   cpu_hold,       1'b1);
      check("rst_busy",       busy,           1'b0);
      check("rst_done",       done,           1'b0);
      check("rst_error",      error,          1'b0);
      @(negedge clock);
      reset = 1'b0;

      // Good two-word frame; cpu_hold must still be high in CHECK and fall after the accept.
      data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
      clear_log();
      pulse_start();
      send_body(16'd2);
      check("t1_busy_in_check", busy,     1'b1);
      check("t1_hold_in_check", cpu_hold, 1'b1);
      send_byte(8'h33);
      bif.byte_valid = 1'b0;
      check("t1_cpu_hold", cpu_hold, 1'b0);
      check("t1_done",     done,     1'b1);
      check("t1_error",    error,    1'b0);
      check("t1_busy",     busy,     1'b0);
      check("t1_nwrites",  wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) begin
         check("t1_addr0", wr_addr_q[0], 12'h000);
         check("t1_data0", wr_data_q[0], 32'h0000_0013);
         check("t1_addr1", wr_addr_q[1], 12'h001);
         check("t1_data1", wr_data_q[1], 32'h0020_0000);
      end

      // Bad checksum, then retry with the correct one.
      load_basic(8'h00);
      check("t2_nwrites",  wr_addr_q.size(), 2);
      check("t2_error",    error,    1'b1);
      check("t2_done",     done,     1'b0);
      check("t2_cpu_hold", cpu_hold, 1'b1);
      load_basic(8'h33);
      check("t2_retry_done",  done,  1'b1);
      check("t2_retry_error", error, 1'b0);

      // Zero and oversize lengths.
      data_q.delete();
      clear_log();
      pulse_start();
      send_body(16'h0000);
      bif.byte_valid = 1'b0;
      check("t3_len0_error", error,          1'b1);
      check("t3_len0_busy",  busy,           1'b0);
      check("t3_len0_rdy",   bif.byte_ready, 1'b0);
      check("t3_len0_hold",  cpu_hold,       1'b1);
      pulse_start();
      send_body(16'h1001);
      bif.byte_valid = 1'b0;
      check("t3_len1001_error", error, 1'b1);
      check("t3_no_writes",     wr_addr_q.size(), 0);

      // Continuous valid, random data, N=3, with a start pulse mid-load that must be ignored.
      data_q.delete();
      exp_w.delete();
      chk = 8'h00;
      for (int i = 0; i < 3; i++) begin
         w = 32'h0;
         for (int j = 0; j < 4; j++) begin
            logic [7:0] b;
            b = 8'($urandom);
            data_q.push_back(b);
            w[j*8 +: 8] = b;
            chk ^= b;
         end
         exp_w.push_back(w);
      end
      clear_log();
      pulse_start();
      send_byte(8'h03);
      send_byte(8'h00);
      for (int i = 0; i < 6; i++) send_byte(data_q[i]);
      start = 1'b1;
      send_byte(data_q[6]);
      start = 1'b0;
      for (int i = 7; i < 12; i++) send_byte(data_q[i]);
      send_byte(chk);
      bif.byte_valid = 1'b0;
      check("t4_nwrites",     wr_addr_q.size(), 3);
      check("t4_rdy_in_write", ready_in_write,  0);
      check("t4_done",        done,  1'b1);
      check("t4_error",       error, 1'b0);
      if (wr_addr_q.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_addr%0d", i), wr_addr_q[i], 32'(i));
            check($sformatf("t4_data%0d", i), wr_data_q[i], exp_w[i]);
         end
      end

      // Reset after 5 data bytes of an N=4 load.
      data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      clear_log();
      pulse_start();
      send_body(16'd4);
      check("t5_pre_busy", busy, 1'b1);
      reset = 1'b1;
      #1;
      check("t5_byte_ready", bif.byte_ready, 1'b0);
      check("t5_mem_wEn",    bif.mem_wEn,    1'b0);
      check("t5_mem_addr",   bif.mem_addr,   12'h000);
      check("t5_mem_dataIn", bif.mem_dataIn, 32'h0);
      check("t5_cpu_hold",   cpu_hold,       1'b1);
      check("t5_busy",       busy,           1'b0);
      check("t5_done",       done,           1'b0);
      check("t5_error",      error,          1'b0);
      bif.byte_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      load_basic(8'h33);
      check("t5_after_done",  done, 1'b1);
      check("t5_after_nwr",   wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) check("t5_after_addr0", wr_addr_q[0], 12'h000);

      // Full-capacity image.
      data_q.delete();
      chk = 8'h00;
      for (int i = 0; i < 4096 * 4; i++) begin
         logic [7:0] b;
         b = 8'((i * 7 + 3) & 255);
         data_q.push_back(b);
         chk ^= b;
      end
      clear_log();
      pulse_start();
      send_body(16'd4096);
      send_byte(chk);
      bif.byte_valid = 1'b0;
      check("t6_done",    done,  1'b1);
      check("t6_error",   error, 1'b0);
      check("t6_nwrites", wr_addr_q.size(), 4096);
      zero_cnt = 0;
      foreach (wr_addr_q[i]) if (wr_addr_q[i] == 12'h000) zero_cnt++;
      check("t6_addr0_writes", zero_cnt, 1);
      if (wr_addr_q.size() == 4096) begin
         w = {data_q[16383], data_q[16382], data_q[16381], data_q[16380]};
         check("t6_last_addr", wr_addr_q[4095], 12'hFFF);
         check("t6_last_data", wr_data_q[4095], w);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
